// File: rtl/decoder_sequencer.sv
// decoder_sequencer: registered WIDTH->NOUT active-low decoder with direct,
// one-shot pulse and auto-scan modes sharing one IDLE/STROBE/GAP sequencer.
`default_nettype none

module decoder_sequencer #(
  parameter int WIDTH = 3,
  parameter int NOUT  = 8,
  parameter int DWELL = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             N_E1,
  input  logic             N_E2,
  input  logic             E3,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] A,
  input  logic             req,
  output logic             busy,
  output logic [WIDTH-1:0] idx,
  output logic [NOUT-1:0]  N_Y
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STROBE = 2'd1;
  localparam logic [1:0] ST_GAP    = 2'd2;

  localparam int MAXC = (DWELL > GAP) ? DWELL : GAP;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0]    DWELL_END = CW'(DWELL - 1);
  localparam logic [CW-1:0]    GAP_END   = CW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [WIDTH-1:0] IDX_LAST  = WIDTH'(NOUT - 1);
  localparam logic [NOUT-1:0]  ONE       = NOUT'(1);

  logic [1:0]       state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [WIDTH-1:0] idx_nx;
  logic             scan_op, scan_op_nx;
  logic             resume, resume_nx;
  logic [NOUT-1:0]  ny_nx;
  logic             busy_nx;

  logic             enabled;
  logic             is_pulse;
  logic             is_scan;
  logic             abort;
  logic [WIDTH-1:0] idx_inc;

  assign enabled  = !N_E1 && !N_E2 && E3;
  assign is_pulse = (mode == 2'b01);
  assign is_scan  = (mode == 2'b10);
  // Any enable loss or departure from the running mode cancels the operation.
  assign abort    = !enabled || (scan_op ? !is_scan : !is_pulse);
  assign idx_inc  = (idx == IDX_LAST) ? '0 : idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      idx     <= '0;
      scan_op <= 1'b0;
      resume  <= 1'b0;
      N_Y     <= '1;
      busy    <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      idx     <= idx_nx;
      scan_op <= scan_op_nx;
      resume  <= resume_nx;
      N_Y     <= ny_nx;
      busy    <= busy_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    idx_nx     = idx;
    scan_op_nx = scan_op;
    resume_nx  = resume;
    case (state)
      ST_IDLE: begin
        if (enabled) begin
          if (is_scan) begin
            state_nx   = ST_STROBE;
            cnt_nx     = '0;
            scan_op_nx = 1'b1;
            idx_nx     = resume ? idx_inc : '0;
            resume_nx  = 1'b0;
          end else if (is_pulse) begin
            if (req) begin
              state_nx   = ST_STROBE;
              cnt_nx     = '0;
              scan_op_nx = 1'b0;
              idx_nx     = A;
              resume_nx  = 1'b0;
            end
          end else begin
            idx_nx    = A;
            resume_nx = 1'b0;
          end
        end
      end
      ST_STROBE: begin
        if (abort) begin
          state_nx  = ST_IDLE;
          resume_nx = scan_op;
        end else if (cnt == DWELL_END) begin
          cnt_nx = '0;
          if (!scan_op) begin
            state_nx = ST_IDLE;
          end else if (GAP == 0) begin
            idx_nx = idx_inc;
          end else begin
            state_nx = ST_GAP;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      ST_GAP: begin
        if (abort) begin
          state_nx  = ST_IDLE;
          resume_nx = 1'b1;
        end else if (cnt == GAP_END) begin
          state_nx = ST_STROBE;
          cnt_nx   = '0;
          idx_nx   = idx_inc;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Shifting past NOUT leaves zero, so out-of-range selects decode to all ones.
  always_comb begin
    ny_nx   = '1;
    busy_nx = (state_nx != ST_IDLE);
    if (state_nx == ST_STROBE) begin
      ny_nx = ~(ONE << idx_nx);
    end else if (state == ST_IDLE && enabled && !is_pulse && !is_scan) begin
      ny_nx = ~(ONE << A);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_decoder_sequencer.sv
// Scoreboard bench: three parameterisations share one stimulus stream; a
// cycle-level reference model predicts every registered output.
`default_nettype none

module tb_decoder_sequencer;

  logic       clk;
  logic       rst;
  logic       n_e1, n_e2, e3, req;
  logic [1:0] mode;
  logic [2:0] a;

  logic       busy_a, busy_b, busy_c;
  logic [2:0] idx_a, idx_b, idx_c;
  logic [7:0] ny_a, ny_b;
  logic [4:0] ny_c;

  decoder_sequencer #(.WIDTH(3), .NOUT(8), .DWELL(4), .GAP(1)) u_a (
    .clk(clk), .rst(rst), .N_E1(n_e1), .N_E2(n_e2), .E3(e3), .mode(mode),
    .A(a), .req(req), .busy(busy_a), .idx(idx_a), .N_Y(ny_a));

  decoder_sequencer #(.WIDTH(3), .NOUT(8), .DWELL(2), .GAP(1)) u_b (
    .clk(clk), .rst(rst), .N_E1(n_e1), .N_E2(n_e2), .E3(e3), .mode(mode),
    .A(a), .req(req), .busy(busy_b), .idx(idx_b), .N_Y(ny_b));

  decoder_sequencer #(.WIDTH(3), .NOUT(5), .DWELL(3), .GAP(0)) u_c (
    .clk(clk), .rst(rst), .N_E1(n_e1), .N_E2(n_e2), .E3(e3), .mode(mode),
    .A(a), .req(req), .busy(busy_c), .idx(idx_c), .N_Y(ny_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] ny;
    logic       busy;
    logic [2:0] idx;
  } exp_t;

  localparam int NO [3] = '{8, 8, 5};
  localparam int DW [3] = '{4, 2, 3};
  localparam int GP [3] = '{1, 1, 0};

  int n_chk  = 0;
  int n_fail = 0;

  exp_t q0[$], q1[$], q2[$];

  // Reference model: act 0 = idle, 1 = pulse, 2 = scan; ph = cycles into current step.
  int act [3];
  int ph  [3];
  int midx[3];
  bit res [3];

  task automatic model_step(input int k, output exp_t e);
    bit en;
    bit dec_direct;
    bit low;
    en = !n_e1 && !n_e2 && e3;
    dec_direct = 1'b0;
    if (rst) begin
      act[k] = 0; ph[k] = 0; midx[k] = 0; res[k] = 1'b0;
    end else if (act[k] != 0) begin
      if (!en || int'(mode) != act[k]) begin
        if (act[k] == 2) res[k] = 1'b1;
        act[k] = 0;
      end else begin
        ph[k]++;
        if (act[k] == 1 && ph[k] == DW[k]) act[k] = 0;
        else if (act[k] == 2 && ph[k] == DW[k] + GP[k]) begin
          ph[k] = 0;
          midx[k] = (midx[k] + 1) % NO[k];
        end
      end
    end else if (en) begin
      if (mode == 2'd1) begin
        if (req) begin act[k] = 1; ph[k] = 0; midx[k] = int'(a); res[k] = 1'b0; end
      end else if (mode == 2'd2) begin
        midx[k] = res[k] ? (midx[k] + 1) % NO[k] : 0;
        act[k] = 2; ph[k] = 0; res[k] = 1'b0;
      end else begin
        midx[k] = int'(a); res[k] = 1'b0; dec_direct = 1'b1;
      end
    end
    low = (act[k] == 1) || (act[k] == 2 && ph[k] < DW[k]) || dec_direct;
    e.ny = 8'hFF;
    if (low && midx[k] < NO[k]) e.ny[midx[k]] = 1'b0;
    e.busy = (act[k] != 0);
    e.idx  = 3'(midx[k]);
  endtask

  always @(posedge clk) begin
    exp_t e;
    model_step(0, e); q0.push_back(e);
    model_step(1, e); q1.push_back(e);
    model_step(2, e); q2.push_back(e);
  end

  task automatic cmp(input string nm, input int k, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s u%0d at %0t: got %0h, expected %0h", nm, k, $time, got, exp);
    end
  endtask

  // Monitor: every cycle each instance presents outputs; pop and compare.
  always @(posedge clk) begin
    exp_t got [3];
    exp_t e;
    bit   have;
    #1;
    got[0] = {ny_a, busy_a, idx_a};
    got[1] = {ny_b, busy_b, idx_b};
    got[2] = {3'b111, ny_c, busy_c, idx_c};
    for (int k = 0; k < 3; k++) begin
      have = 1'b1;
      e = '0;
      case (k)
        0: if (q0.size() > 0) e = q0.pop_front(); else have = 1'b0;
        1: if (q1.size() > 0) e = q1.pop_front(); else have = 1'b0;
        default: if (q2.size() > 0) e = q2.pop_front(); else have = 1'b0;
      endcase
      if (!have) begin
        n_chk++; n_fail++;
        $display("FAIL scoreboard_empty u%0d at %0t: got none, expected entry", k, $time);
      end else begin
        cmp("N_Y",  k, int'(got[k].ny),   int'(e.ny));
        cmp("busy", k, int'(got[k].busy), int'(e.busy));
        cmp("idx",  k, int'(got[k].idx),  int'(e.idx));
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    cmp(nm, 9, got, exp);
  endtask

  initial begin
    int   cnt_fb, cnt_bad, cnt_busy, w;
    logic [7:0] e8;
    rst = 1'b1; n_e1 = 1'b0; n_e2 = 1'b0; e3 = 1'b1;
    mode = 2'd0; a = 3'd5; req = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ny_a", int'(ny_a), 'hFF);
    chk("reset_busy_a", int'(busy_a), 0);
    chk("reset_ny_c", int'(ny_c), 'h1F);
    rst = 1'b0;
    @(negedge clk);
    chk("direct_a5_ny", int'(ny_a), 'hDF);
    chk("direct_a5_idx", int'(idx_a), 5);

    for (int i = 0; i < 8; i++) begin
      a = 3'(i);
      @(negedge clk);
      e8 = 8'hFF; e8[i] = 1'b0;
      chk("sweep_ny", int'(ny_a), int'(e8));
    end
    n_e1 = 1'b1;
    @(negedge clk);
    chk("disabled_ny", int'(ny_a), 'hFF);

    // Pulse on A=2 with a second request issued while busy.
    n_e1 = 1'b0; mode = 2'd1; a = 3'd2;
    @(negedge clk);
    req = 1'b1;
    cnt_fb = 0; cnt_bad = 0; cnt_busy = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (ny_a == 8'hFB) cnt_fb++;
      else if (ny_a != 8'hFF) cnt_bad++;
      if (busy_a) cnt_busy++;
      if (k == 1) begin req = 1'b0; a = 3'd6; end
      if (k == 2) req = 1'b1;
      if (k == 3) req = 1'b0;
    end
    chk("pulse_low_cycles", cnt_fb, 4);
    chk("pulse_other_low", cnt_bad, 0);
    chk("pulse_busy_cycles", cnt_busy, 4);

    // Scan, then drop E3 while u_b strobes idx 3.
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    mode = 2'd2;
    repeat (60) @(negedge clk);
    w = 0;
    while (w < 100 && !(idx_b == 3'd3 && ny_b != 8'hFF)) begin
      @(negedge clk); w++;
    end
    chk("scan_reach_idx3_timeout", int'(w < 100), 1);
    e3 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("drop_ny_b", int'(ny_b), 'hFF);
      chk("drop_busy_b", int'(busy_b), 0);
    end
    e3 = 1'b1;
    w = 0;
    do begin @(negedge clk); w++; end while (w < 10 && ny_b == 8'hFF);
    chk("resume_idx_b", int'(idx_b), 4);
    chk("resume_ny_b", int'(ny_b), 'hEF);

    // Reset mid-pulse and mid-scan.
    mode = 2'd1; a = 3'd3; req = 1'b1;
    @(negedge clk); req = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("rst_pulse_ny_a", int'(ny_a), 'hFF);
    chk("rst_pulse_busy_a", int'(busy_a), 0);
    chk("rst_pulse_idx_a", int'(idx_a), 0);
    mode = 2'd2;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("rst_scan_ny_b", int'(ny_b), 'hFF);
    chk("rst_scan_busy_b", int'(busy_b), 0);
    chk("rst_scan_idx_b", int'(idx_b), 0);

    // Out-of-range select on the NOUT=5 instance.
    mode = 2'd0; a = 3'd6;
    @(negedge clk);
    chk("oor_ny_c", int'(ny_c), 'h1F);
    chk("a6_ny_a", int'(ny_a), 'hBF);

    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      rst  = ($urandom_range(0, 63) == 0);
      n_e1 = ($urandom_range(0, 11) == 0);
      n_e2 = ($urandom_range(0, 11) == 0);
      e3   = ($urandom_range(0, 11) != 0);
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      a    = 3'($urandom_range(0, 7));
      req  = ($urandom_range(0, 2) == 0);
    end
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
